// File: rtl/cavlc_coeff_stats.sv
// Per-block CAVLC coefficient statistics: TotalCoeff, TrailingOnes, trailing-one
// signs, TotalZeros, plus a level/run_before buffer readable after the scan.
module cavlc_coeff_stats #(
  parameter int COEF_W    = 9,
  parameter int MAX_COEFF = 16,
  parameter int CW        = $clog2(MAX_COEFF + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CW-1:0]     blk_len,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef,
  output logic              coef_ready,
  output logic              done,
  output logic              stats_valid,
  output logic [CW-1:0]     total_coeff,
  output logic [1:0]        trail_ones,
  output logic [2:0]        trail_sign,
  output logic [CW-1:0]     total_zeros,
  input  logic [CW-1:0]     rd_idx,
  output logic [COEF_W-1:0] rd_level,
  output logic [CW-1:0]     rd_run
);

  localparam int AW = (MAX_COEFF > 1) ? $clog2(MAX_COEFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     tc_q, tc_d;
  logic [1:0]        t1_q, t1_d;
  logic [2:0]        ts_q, ts_d;
  logic [CW-1:0]     tz_q, tz_d;
  logic              stop_q, stop_d;
  logic              done_q, done_d;
  logic              sv_q, sv_d;
  logic [COEF_W-1:0] rd_level_q;
  logic [CW-1:0]     rd_run_q;

  logic [COEF_W-1:0] level_q [MAX_COEFF];
  logic [CW-1:0]     run_q   [MAX_COEFF];

  logic              clr_s, acc_s, nz_s, mag_one_s, sign_s;
  logic [CW-1:0]     last_s;
  logic [AW-1:0]     wr_idx_s, last_idx_s, rd_addr_s;

  assign nz_s       = (coef[COEF_W-2:0] != '0);
  assign mag_one_s  = (coef[COEF_W-2:0] == (COEF_W-1)'(1));
  assign sign_s     = coef[COEF_W-1];
  assign last_s     = tc_q - CW'(1);
  assign wr_idx_s   = tc_q[AW-1:0];
  assign last_idx_s = last_s[AW-1:0];
  assign rd_addr_s  = rd_idx[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tc_q    <= '0;
      t1_q    <= 2'd0;
      ts_q    <= 3'd0;
      tz_q    <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      t1_q    <= t1_d;
      ts_q    <= ts_d;
      tz_q    <= tz_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      sv_q    <= sv_d;
    end
  end

  // start always wins: in SCAN a coefficient arriving with start is dropped
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tc_d    = tc_q;
    t1_d    = t1_q;
    ts_d    = ts_q;
    tz_d    = tz_q;
    stop_d  = stop_q;
    sv_d    = sv_q;
    done_d  = 1'b0;
    clr_s   = 1'b0;
    acc_s   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr_s   = 1'b1;
          state_d = S_SCAN;
        end else begin
          state_d = state_q;
        end
      end
      S_SCAN: begin
        if (start) begin
          clr_s = 1'b1;
        end else begin
          acc_s = coef_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_s) begin
      len_d  = blk_len;
      cnt_d  = '0;
      tc_d   = '0;
      t1_d   = 2'd0;
      ts_d   = 3'd0;
      tz_d   = '0;
      stop_d = 1'b0;
      sv_d   = 1'b0;
    end else if (acc_s) begin
      cnt_d = cnt_q + CW'(1);
      if (nz_s) begin
        tc_d = tc_q + CW'(1);
        if (mag_one_s && !stop_q && (t1_q != 2'd3)) begin
          case (t1_q)
            2'd0:    ts_d[0] = sign_s;
            2'd1:    ts_d[1] = sign_s;
            2'd2:    ts_d[2] = sign_s;
            default: ts_d = ts_q;
          endcase
          t1_d = t1_q + 2'd1;
        end else begin
          stop_d = 1'b1;
        end
      end else if (tc_q != '0) begin
        tz_d = tz_q + CW'(1);
      end else begin
        tz_d = tz_q;
      end
      if (cnt_d == len_q) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        sv_d    = 1'b1;
      end else begin
        state_d = S_SCAN;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Level/run buffer; zeros before the first non-zero have no entry to extend
  always_ff @(posedge clk) begin
    if (acc_s && nz_s) begin
      level_q[wr_idx_s] <= coef;
      run_q[wr_idx_s]   <= '0;
    end else if (acc_s && (tc_q != '0)) begin
      run_q[last_idx_s] <= run_q[last_idx_s] + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_level_q <= '0;
      rd_run_q   <= '0;
    end else if (rd_idx < tc_q) begin
      rd_level_q <= level_q[rd_addr_s];
      rd_run_q   <= run_q[rd_addr_s];
    end else begin
      rd_level_q <= '0;
      rd_run_q   <= '0;
    end
  end

  assign coef_ready  = (state_q == S_SCAN);
  assign done        = done_q;
  assign stats_valid = sv_q;
  assign total_coeff = tc_q;
  assign trail_ones  = t1_q;
  assign trail_sign  = ts_q;
  assign total_zeros = tz_q;
  assign rd_level    = rd_level_q;
  assign rd_run      = rd_run_q;

endmodule

// File: tb/tb_cavlc_coeff_stats.sv
// Directed, table-driven bench for cavlc_coeff_stats with hand-computed results
// plus abort and mid-scan reset sequences.
module tb_cavlc_coeff_stats;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] blk_len;
  logic       coef_valid;
  logic [8:0] coef;
  logic       coef_ready;
  logic       done;
  logic       stats_valid;
  logic [4:0] total_coeff;
  logic [1:0] trail_ones;
  logic [2:0] trail_sign;
  logic [4:0] total_zeros;
  logic [4:0] rd_idx;
  logic [8:0] rd_level;
  logic [4:0] rd_run;

  int total;
  int bad;

  cavlc_coeff_stats #(.COEF_W(9), .MAX_COEFF(16)) dut (
    .clk(clk), .rst(rst), .start(start), .blk_len(blk_len),
    .coef_valid(coef_valid), .coef(coef), .coef_ready(coef_ready),
    .done(done), .stats_valid(stats_valid), .total_coeff(total_coeff),
    .trail_ones(trail_ones), .trail_sign(trail_sign), .total_zeros(total_zeros),
    .rd_idx(rd_idx), .rd_level(rd_level), .rd_run(rd_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         len;
    logic [8:0] c [16];
    logic [15:0] gap;
    int         tc;
    int         t1;
    logic [2:0] ts;
    int         tz;
    int         nent;
    logic [8:0] lv [16];
    int         rn [16];
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm, input int exp_cyc, input int cyc_in);
    int cyc;
    int waited;
    cyc = cyc_in;
    waited = 0;
    while (!done && waited < 4) begin
      @(negedge clk);
      cyc++;
      waited++;
    end
    chk({nm, "_done_cycle"}, cyc, exp_cyc);
  endtask

  task automatic run_vec(input int i);
    int cyc;
    int early;
    int gaps;
    string p;
    p = $sformatf("v%0d", i);
    @(negedge clk);
    start = 1'b1; blk_len = 5'(vt[i].len); coef_valid = 1'b0; cyc = 1;
    @(negedge clk);
    start = 1'b0; cyc = 2;
    chk({p, "_ready_after_start"}, coef_ready, 1);
    chk({p, "_sv_cleared"}, stats_valid, 0);
    chk({p, "_tc_cleared"}, total_coeff, 0);
    early = 0; gaps = 0;
    for (int k = 0; k < vt[i].len; k++) begin
      if (vt[i].gap[k]) begin
        coef_valid = 1'b0; coef = 9'h1FF;
        @(negedge clk);
        cyc++; gaps++;
        if (done) early++;
      end
      coef_valid = 1'b1; coef = vt[i].c[k];
      @(negedge clk);
      cyc++;
      if (k != vt[i].len - 1 && done) early++;
    end
    coef_valid = 1'b0; coef = 9'h000;
    chk({p, "_done_early"}, early, 0);
    wait_done(p, vt[i].len + 2 + gaps, cyc);
    chk({p, "_sv_with_done"}, stats_valid, 1);
    chk({p, "_tc"}, total_coeff, vt[i].tc);
    chk({p, "_t1"}, trail_ones, vt[i].t1);
    chk({p, "_ts"}, trail_sign, vt[i].ts);
    chk({p, "_tz"}, total_zeros, vt[i].tz);
    @(negedge clk);
    chk({p, "_done_one_cycle"}, done, 0);
    chk({p, "_sv_hold"}, stats_valid, 1);
    chk({p, "_ready_low"}, coef_ready, 0);
    for (int e = 0; e < vt[i].nent; e++) begin
      rd_idx = 5'(e);
      @(negedge clk);
      chk($sformatf("%s_lvl%0d", p, e), rd_level, vt[i].lv[e]);
      chk($sformatf("%s_run%0d", p, e), rd_run, vt[i].rn[e]);
    end
    rd_idx = 5'(vt[i].nent);
    @(negedge clk);
    chk({p, "_lvl_past_end"}, rd_level, 0);
    chk({p, "_run_past_end"}, rd_run, 0);
    rd_idx = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [8:0] old [5];
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; blk_len = 5'd0; coef_valid = 1'b0; coef = 9'h000; rd_idx = 5'd0;

    // reverse-scan block
    vt[0].len = 16; vt[0].gap = 16'h0000;
    vt[0].c  = '{9:9'h101, 12:9'h103, 13:9'h003, 14:9'h004, 15:9'h102, default:9'h000};
    vt[0].tc = 5; vt[0].t1 = 1; vt[0].ts = 3'b001; vt[0].tz = 2; vt[0].nent = 5;
    vt[0].lv = '{0:9'h101, 1:9'h103, 2:9'h003, 3:9'h004, 4:9'h102, default:9'h000};
    vt[0].rn = '{0:2, default:0};
    // all zeros
    vt[1].len = 16; vt[1].gap = 16'h0000;
    vt[1].c  = '{default:9'h000};
    vt[1].tc = 0; vt[1].t1 = 0; vt[1].ts = 3'b000; vt[1].tz = 0; vt[1].nent = 0;
    vt[1].lv = '{default:9'h000};
    vt[1].rn = '{default:0};
    // four ones
    vt[2].len = 16; vt[2].gap = 16'h0000;
    vt[2].c  = '{0:9'h001, 1:9'h101, 2:9'h001, 3:9'h101, default:9'h000};
    vt[2].tc = 4; vt[2].t1 = 3; vt[2].ts = 3'b010; vt[2].tz = 12; vt[2].nent = 4;
    vt[2].lv = '{0:9'h001, 1:9'h101, 2:9'h001, 3:9'h101, default:9'h000};
    vt[2].rn = '{3:12, default:0};
    // chroma DC
    vt[3].len = 4; vt[3].gap = 16'h0000;
    vt[3].c  = '{1:9'h002, 3:9'h101, default:9'h000};
    vt[3].tc = 2; vt[3].t1 = 0; vt[3].ts = 3'b000; vt[3].tz = 1; vt[3].nent = 2;
    vt[3].lv = '{0:9'h002, 1:9'h101, default:9'h000};
    vt[3].rn = '{0:1, default:0};
    // first block again with valid gaps
    vt[4] = vt[0];
    vt[4].gap = 16'h04A1;
    // 15-coefficient block: a large level first blocks all trailing ones
    vt[5].len = 15; vt[5].gap = 16'h0000;
    vt[5].c  = '{0:9'h105, 1:9'h001, 2:9'h101, default:9'h000};
    vt[5].tc = 3; vt[5].t1 = 0; vt[5].ts = 3'b000; vt[5].tz = 12; vt[5].nent = 3;
    vt[5].lv = '{0:9'h105, 1:9'h001, 2:9'h101, default:9'h000};
    vt[5].rn = '{2:12, default:0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", coef_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_sv", stats_valid, 0);
    chk("rst_tc", total_coeff, 0);
    chk("rst_t1", trail_ones, 0);
    chk("rst_ts", trail_sign, 0);
    chk("rst_tz", total_zeros, 0);
    chk("rst_lvl", rd_level, 0);
    chk("rst_run", rd_run, 0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // abort after 5 coefficients; coefficient arriving with start is dropped
    old = '{9'h101, 9'h105, 9'h000, 9'h001, 9'h003};
    @(negedge clk);
    start = 1'b1; blk_len = 5'd16;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      coef_valid = 1'b1; coef = old[k];
      @(negedge clk);
    end
    start = 1'b1; coef_valid = 1'b1; coef = 9'h107;
    @(negedge clk);
    start = 1'b0; cyc = 2;
    chk("abort_tc_cleared", total_coeff, 0);
    chk("abort_ready", coef_ready, 1);
    for (int k = 0; k < 16; k++) begin
      coef = vt[2].c[k];
      @(negedge clk);
      cyc++;
    end
    coef_valid = 1'b0;
    wait_done("abort", 18, cyc);
    chk("abort_tc", total_coeff, 4);
    chk("abort_t1", trail_ones, 3);
    chk("abort_ts", trail_sign, 3'b010);
    chk("abort_tz", total_zeros, 12);
    rd_idx = 5'd0;
    @(negedge clk);
    chk("abort_lvl0", rd_level, 9'h001);
    chk("abort_run0", rd_run, 0);
    rd_idx = 5'd3;
    @(negedge clk);
    chk("abort_lvl3", rd_level, 9'h101);
    chk("abort_run3", rd_run, 12);

    // start while in DONE with a coefficient present: not accepted
    start = 1'b1; blk_len = 5'd4; coef_valid = 1'b1; coef = 9'h001;
    @(negedge clk);
    start = 1'b0; coef_valid = 1'b0;
    chk("restart_tc", total_coeff, 0);
    chk("restart_t1", trail_ones, 0);

    // reset in the middle of a scan
    rd_idx = 5'd0;
    coef_valid = 1'b1; coef = 9'h103;
    @(negedge clk);
    coef = 9'h001;
    @(negedge clk);
    coef = 9'h000;
    @(negedge clk);
    chk("pre_rst_tc", total_coeff, 2);
    rst = 1'b1; coef = 9'h005;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", coef_ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sv", stats_valid, 0);
    chk("mid_rst_tc", total_coeff, 0);
    chk("mid_rst_t1", trail_ones, 0);
    chk("mid_rst_ts", trail_sign, 0);
    chk("mid_rst_tz", total_zeros, 0);
    chk("mid_rst_lvl", rd_level, 0);
    chk("mid_rst_run", rd_run, 0);
    repeat (2) @(negedge clk);
    coef_valid = 1'b0;
    chk("idle_ignores_tc", total_coeff, 0);
    chk("idle_ready", coef_ready, 0);
    chk("idle_stale_lvl", rd_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
